hack_ins_fetch: RTL and testbench

// - Instruction fetch stage upstream of the Hack CPU control FSM: issues ROM reads, buffers returned words,

---
 rtl/hack_pkg.sv | 28 ++
 rtl/hack_fetch_fifo.sv | 66 ++++++
 rtl/hack_ins_fetch.sv | 121 ++++++++++++
 tb/tb_hack_ins_fetch.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// hack_pkg: shared Hack CPU widths, types and fetch-stage state encoding
// Contents:
//   ADDR_W / WORD_W   ROM address and instruction widths
//   hack_addr_t       15-bit ROM word address
//   hack_word_t       16-bit instruction word
//   fetch_state_t     fetch stage FSM states (S_INIT, S_RUN, S_DRAIN)
//   sat_add16         16-bit saturating add used by the optional statistics
package hack_pkg;

    localparam int ADDR_W = 15;
    localparam int WORD_W = 16;

    typedef logic [ADDR_W-1:0] hack_addr_t;
    typedef logic [WORD_W-1:0] hack_word_t;

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_DRAIN
    } fetch_state_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/hack_fetch_fifo.sv
// hack_fetch_fifo: prefetch buffer of {pc, word} entries with push/pop/clear
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   clear                 empties the buffer; wins over push and pop
//   push, push_pc/word    write one entry at the tail
//   pop                   drop the head entry (caller guarantees not empty)
//   head_pc, head_word    head entry; zero after reset
//   count, full, empty    occupancy
module hack_fetch_fifo
    import hack_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   push,
    input  hack_addr_t             push_pc,
    input  hack_word_t             push_word,
    input  logic                   pop,
    output hack_addr_t             head_pc,
    output hack_word_t             head_word,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);

    hack_addr_t    pc_mem   [DEPTH];
    hack_word_t    word_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                word_mem[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]   <= push_pc;
                word_mem[wr_ptr] <= push_word;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    assign head_pc   = pc_mem[rd_ptr];
    assign head_word = word_mem[rd_ptr];
    assign full      = count == (PW+1)'(DEPTH);
    assign empty     = count == '0;

endmodule

// File: rtl/hack_ins_fetch.sv
// hack_ins_fetch: Hack CPU instruction fetch stage with prefetch buffer and jump redirect
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   rom_req, rom_addr               ROM read strobe and word address
//   rom_rvalid, rom_rdata           in-order ROM read response
//   ins, ins_pc, ins_valid          buffered instruction handed to the decoder
//   ins_ready                       decoder accepts ins when ins_valid & ins_ready
//   redirect, redir_pc              taken jump pulse and its target
//   stat_fetched, stat_flushed      saturating counters, only with HACK_FETCH_STATS_EN
// Build option: define HACK_FETCH_STATS_EN to add the statistics counters.
module hack_ins_fetch
    import hack_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        rom_req,
    output hack_addr_t  rom_addr,
    input  logic        rom_rvalid,
    input  hack_word_t  rom_rdata,
    output hack_word_t  ins,
    output hack_addr_t  ins_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    input  logic        redirect,
    input  hack_addr_t  redir_pc
`ifdef HACK_FETCH_STATS_EN
    ,
    output logic [15:0] stat_fetched,
    output logic [15:0] stat_flushed
`endif
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state;
    hack_addr_t    fetch_pc;
    hack_addr_t    resp_pc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] drop_cnt;
    logic [OW-1:0] drop_nxt;
    logic [CW-1:0] buf_count;
    logic          buf_full;
    logic          buf_empty;
    logic          active;
    logic          flush;
    logic          drop;
    logic          push;
    logic          pop;

    assign active = state != S_INIT;
    assign flush  = active & redirect;
    // A response arriving with the redirect belongs to the old stream.
    assign drop   = active & rom_rvalid & (redirect | (drop_cnt != '0));
    assign push   = active & rom_rvalid & ~drop;
    assign pop    = ins_valid & ins_ready & ~flush;

    // Live (non-dropped) reads in flight already own a buffer slot; on a
    // redirect everything in flight is stale, so only the read limit applies.
    assign rom_req  = active && int'(outstanding) < MAX_OUT &&
                      (flush || (!buf_full && int'(buf_count) + int'(outstanding - drop_cnt) < DEPTH));
    assign rom_addr = flush ? redir_pc : fetch_pc;

    assign drop_nxt = flush ? outstanding - OW'(rom_rvalid) : drop_cnt - OW'(drop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_INIT;
            fetch_pc    <= '0;
            resp_pc     <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (state == S_INIT) begin
            state    <= S_RUN;
            fetch_pc <= redirect ? redir_pc : fetch_pc;
            resp_pc  <= redirect ? redir_pc : resp_pc;
        end else begin
            state       <= drop_nxt != '0 ? S_DRAIN : S_RUN;
            drop_cnt    <= drop_nxt;
            outstanding <= outstanding + OW'(rom_req) - OW'(rom_rvalid);
            fetch_pc    <= rom_addr + hack_addr_t'(rom_req);
            // resp_pc is the address the next live response belongs to.
            resp_pc     <= flush ? redir_pc : resp_pc + hack_addr_t'(push);
        end
    end

    hack_fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (flush),
        .push     (push),
        .push_pc  (resp_pc),
        .push_word(rom_rdata),
        .pop      (pop),
        .head_pc  (ins_pc),
        .head_word(ins),
        .count    (buf_count),
        .full     (buf_full),
        .empty    (buf_empty)
    );

    assign ins_valid = ~buf_empty;

`ifdef HACK_FETCH_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_fetched <= '0;
            stat_flushed <= '0;
        end else begin
            stat_fetched <= sat_add16(stat_fetched, 16'(pop));
            stat_flushed <= sat_add16(stat_flushed, (flush ? 16'(buf_count) : 16'd0) + 16'(drop));
        end
    end
`endif

endmodule

// File: tb/tb_hack_ins_fetch.sv
// tb_hack_ins_fetch: randomized self-checking bench for hack_ins_fetch against a program-order model
module tb_hack_ins_fetch;

    localparam int DEPTH   = 2;
    localparam int MAX_OUT = 2;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic        rom_req;
    logic [14:0] rom_addr;
    logic        rom_rvalid = 1'b0;
    logic [15:0] rom_rdata  = 16'h0;
    logic [15:0] ins;
    logic [14:0] ins_pc;
    logic        ins_valid;
    logic        ins_ready  = 1'b0;
    logic        redirect   = 1'b0;
    logic [14:0] redir_pc   = 15'h0;
`ifdef HACK_FETCH_STATS_EN
    logic [15:0] stat_fetched;
    logic [15:0] stat_flushed;
    int          fetched;
    int          resp_cnt;
`endif

    typedef struct {
        logic [14:0] addr;
        int          due;
    } rd_t;

    rd_t         q[$];
    logic [14:0] req_log[$];
    logic [14:0] hs_log[$];
    int          cyc, lat, last_due, idle, first_valid;
    int          errors, checks;
    logic [14:0] issue_pc, exp_pc, prev_pc;
    logic [15:0] prev_ins;
    logic        prev_stall, prev_redir, stale_now, hit;

    always #5 clk = ~clk;

    hack_ins_fetch #(
        .DEPTH  (DEPTH),
        .MAX_OUT(MAX_OUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rom_req     (rom_req),
        .rom_addr    (rom_addr),
        .rom_rvalid  (rom_rvalid),
        .rom_rdata   (rom_rdata),
        .ins         (ins),
        .ins_pc      (ins_pc),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .redirect    (redirect),
        .redir_pc    (redir_pc)
`ifdef HACK_FETCH_STATS_EN
        ,
        .stat_fetched(stat_fetched),
        .stat_flushed(stat_flushed)
`endif
    );

    // ROM contents: any fixed, address-dependent pattern.
    function automatic logic [15:0] rom_word(input logic [14:0] a);
        return {a[6:0], a[14:7] ^ 8'hA5} ^ 16'h3C1B;
    endfunction

    function automatic logic [31:0] hs_at(input int i);
        return i < hs_log.size() ? 32'(hs_log[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] req_at(input int i);
        return i < req_log.size() ? 32'(req_log[i]) : 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reset_model();
        q.delete();
        req_log.delete();
        hs_log.delete();
        cyc         = 0;
        last_due    = 0;
        idle        = 0;
        first_valid = -1;
        issue_pc    = '0;
        exp_pc      = '0;
        prev_pc     = '0;
        prev_ins    = '0;
        prev_stall  = 1'b0;
        prev_redir  = 1'b0;
        stale_now   = 1'b0;
`ifdef HACK_FETCH_STATS_EN
        fetched  = 0;
        resp_cnt = 0;
`endif
    endtask

    // One clock cycle, entered and left on a falling edge. Inputs are driven,
    // outputs checked against the program-order model, then the edge is taken.
    task automatic cycle(input logic rdy, input logic rd, input logic [14:0] rpc);
        ins_ready  = rdy;
        redirect   = rd;
        redir_pc   = rpc;
        rom_rvalid = 1'b0;
        rom_rdata  = 16'h0;
        if (stale_now) begin
            rom_rvalid = 1'b1;
            rom_rdata  = 16'hDEAD;
            stale_now  = 1'b0;
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            rom_rvalid = 1'b1;
            rom_rdata  = rom_word(q[0].addr);
            void'(q.pop_front());
        end
        #1;
        if (prev_redir)
            chk("flush_clears_valid", 32'(ins_valid), 0);
        else if (prev_stall) begin
            chk("stall_valid", 32'(ins_valid), 1);
            chk("stall_pc", 32'(ins_pc), 32'(prev_pc));
            chk("stall_ins", 32'(ins), 32'(prev_ins));
        end
`ifdef HACK_FETCH_STATS_EN
        if (prev_redir) begin
            chk("stat_fetched", 32'(stat_fetched), 32'(fetched));
            chk("stat_flushed", 32'(stat_flushed), 32'(resp_cnt - fetched));
        end
        if (rom_rvalid && cyc != 0)
            resp_cnt++;
`endif
        if (ins_valid) begin
            if (first_valid < 0)
                first_valid = cyc;
            chk("head_pc", 32'(ins_pc), 32'(exp_pc));
            chk("head_ins", 32'(ins), 32'(rom_word(ins_pc)));
        end
        if (ins_valid && rdy && !rd) begin
            hs_log.push_back(ins_pc);
            exp_pc = exp_pc + 15'd1;
            idle   = 0;
`ifdef HACK_FETCH_STATS_EN
            fetched++;
`endif
        end else
            idle = (rdy && !rd) ? idle + 1 : 0;
        chk("progress", 32'(idle <= 25), 1);
        if (rd) begin
            exp_pc   = rpc;
            issue_pc = rpc;
        end
        if (rom_req) begin
            chk("req_addr", 32'(rom_addr), 32'(issue_pc));
            req_log.push_back(rom_addr);
            issue_pc = issue_pc + 15'd1;
            last_due = (cyc + lat > last_due) ? cyc + lat : last_due;
            q.push_back('{rom_addr, last_due});
            chk("outstanding", 32'(q.size() <= MAX_OUT), 1);
        end
        prev_stall = ins_valid && !rdy && !rd;
        prev_redir = rd;
        prev_pc    = ins_pc;
        prev_ins   = ins;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        lat    = 1;
        hit    = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(ins_valid), 0);
        chk("reset_ins", 32'(ins), 0);
        chk("reset_pc", 32'(ins_pc), 0);
        chk("reset_req", 32'(rom_req), 0);
        chk("reset_addr", 32'(rom_addr), 0);
        reset_n = 1'b1;

        // Straight-line fetch, latency 1, consumer always ready.
        repeat (12) cycle(1'b1, 1'b0, 15'h0);
        chk("first_valid_cycle", 32'(first_valid), 3);
        chk("req0", req_at(0), 0);
        chk("req1", req_at(1), 1);
        chk("req2", req_at(2), 2);
        chk("hs0", hs_at(0), 0);
        chk("hs1", hs_at(1), 1);
        chk("hs2", hs_at(2), 2);

        // Consumer stalls: buffer fills and requests stop.
        repeat (10) cycle(1'b0, 1'b0, 15'h0);
        chk("stall_no_req", 32'(rom_req), 0);
        chk("stall_full_valid", 32'(ins_valid), 1);
        hs_log.delete();
        repeat (10) cycle(1'b1, 1'b0, 15'h0);
        chk("stall_release_progress", 32'(hs_log.size() >= 3), 1);

        // Latency 3, redirect with two reads in flight.
        lat = 3;
        for (int i = 0; i < 20 && q.size() < MAX_OUT; i++)
            cycle(1'b1, 1'b0, 15'h0);
        chk("two_in_flight", 32'(q.size()), 2);
        hs_log.delete();
        cycle(1'b1, 1'b1, 15'h0100);
        repeat (20) cycle(1'b1, 1'b0, 15'h0);
        chk("redir_first_pc", hs_at(0), 32'h0100);
        chk("redir_second_pc", hs_at(1), 32'h0101);

        // Address wrap at the top of ROM.
        lat = 1;
        hs_log.delete();
        cycle(1'b1, 1'b1, 15'h7FFE);
        repeat (20) cycle(1'b1, 1'b0, 15'h0);
        chk("wrap_pc0", hs_at(0), 32'h7FFE);
        chk("wrap_pc1", hs_at(1), 32'h7FFF);
        chk("wrap_pc2", hs_at(2), 32'h0000);

        // Redirect coinciding with a ready consumer and an arriving response.
        for (int i = 0; i < 40; i++) begin
            if (!hit && ins_valid && q.size() > 0 && q[0].due <= cyc) begin
                hs_log.delete();
                cycle(1'b1, 1'b1, 15'h0200);
                hit = 1'b1;
            end else
                cycle(1'b1, 1'b0, 15'h0);
        end
        chk("triple_event_seen", 32'(hit), 1);
        chk("triple_first_pc", hs_at(0), 32'h0200);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            lat = int'($urandom_range(1, 4));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, 15'($urandom));
        end

        // Asynchronous reset with reads in flight.
        lat = 3;
        for (int i = 0; i < 10 && q.size() == 0; i++)
            cycle(1'b1, 1'b0, 15'h0);
        chk("reads_in_flight", 32'(q.size() > 0), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(ins_valid), 0);
        chk("async_rst_ins", 32'(ins), 0);
        chk("async_rst_pc", 32'(ins_pc), 0);
        chk("async_rst_req", 32'(rom_req), 0);
        chk("async_rst_addr", 32'(rom_addr), 0);
`ifdef HACK_FETCH_STATS_EN
        chk("async_rst_fetched", 32'(stat_fetched), 0);
        chk("async_rst_flushed", 32'(stat_flushed), 0);
`endif
        ins_ready  = 1'b0;
        redirect   = 1'b0;
        rom_rvalid = 1'b0;
        reset_model();
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        stale_now = 1'b1;
        lat       = 1;
        repeat (15) cycle(1'b1, 1'b0, 15'h0);
        chk("restart_first_valid", 32'(first_valid), 3);
        chk("restart_pc0", hs_at(0), 0);
        chk("restart_pc1", hs_at(1), 1);
        cycle(1'b1, 1'b1, 15'h0010);
        repeat (10) cycle(1'b1, 1'b0, 15'h0);
        chk("final_redir_pc", hs_at(hs_log.size() > 0 ? hs_log.size() - 1 : 0) != 32'hFFFF_FFFF, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
